// File: rtl/move_scheduler.sv
// move_scheduler: tick-driven round-robin mover owning the object position register.
// Ports: clk, rst (async, active-high); req_a/dir_a, req_b/dir_b movement requests,
//        dir = {up, down, left, right}; center recenters next edge; gnt_a/gnt_b one-cycle
//        grants in APPLY; tick pulses once per TICK_CYCLES; busy high in ARB/APPLY;
//        x_pos/y_pos current position.
// Build option: define MOVE_SCHED_WRAP_EN to wrap at the screen edges instead of clamping.
module move_scheduler #(
    parameter int TICK_CYCLES = 250_000,
    parameter int STEP        = 1,
    parameter int X_MAX       = 639,
    parameter int Y_MAX       = 479,
    parameter int X_CENTER    = 320,
    parameter int Y_CENTER    = 240
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_a,
    input  logic [3:0]  dir_a,
    input  logic        req_b,
    input  logic [3:0]  dir_b,
    input  logic        center,
    output logic        gnt_a,
    output logic        gnt_b,
    output logic        tick,
    output logic        busy,
    output logic [15:0] x_pos,
    output logic [15:0] y_pos
);
    localparam int CW = $clog2(TICK_CYCLES);

    typedef enum logic [1:0] {WAIT, ARB, APPLY} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          last_q, last_d;
    logic          win_a_q, win_a_d, win_b_q, win_b_d;
    logic [3:0]    dir_q, dir_d;
    logic [15:0]   x_q, x_d, y_q, y_d;

    // One axis step in 17 bits so a decrement below zero shows up as bit 16.
    function automatic logic [15:0] step_axis(input logic [15:0] v, input logic inc,
                                              input logic dec, input logic [16:0] mx);
        logic [16:0] dn, up;
        dn = {1'b0, v} - 17'(STEP);
        up = {1'b0, v} + 17'(STEP);
`ifdef MOVE_SCHED_WRAP_EN
        dn = dn[16] ? dn + mx + 17'd1 : dn;
        up = up > mx ? up - mx - 17'd1 : up;
`else
        dn = dn[16] ? 17'd0 : dn;
        up = up > mx ? mx : up;
`endif
        return (inc && !dec) ? up[15:0] : (dec && !inc) ? dn[15:0] : v;
    endfunction

    assign tick  = count_q == CW'(TICK_CYCLES - 1);
    assign busy  = state_q != WAIT;
    assign gnt_a = state_q == APPLY && win_a_q && !center;
    assign gnt_b = state_q == APPLY && win_b_q && !center;
    assign x_pos = x_q;
    assign y_pos = y_q;

    always_comb begin
        count_d = tick ? '0 : count_q + CW'(1);
        state_d = state_q;
        last_d  = last_q;
        win_a_d = win_a_q;
        win_b_d = win_b_q;
        dir_d   = dir_q;
        x_d     = x_q;
        y_d     = y_q;
        case (state_q)
            WAIT: state_d = tick ? ARB : WAIT;
            ARB: begin
                state_d = APPLY;
                // last_q == 1 means B was granted last, so A wins a contended tick.
                win_a_d = req_a && (!req_b || last_q);
                win_b_d = req_b && (!req_a || !last_q);
                dir_d   = win_a_d ? dir_a : dir_b;
            end
            APPLY: begin
                state_d = WAIT;
                if (win_a_q || win_b_q) begin
                    last_d = win_b_q;
                    x_d    = step_axis(x_q, dir_q[0], dir_q[1], 17'(X_MAX));
                    y_d    = step_axis(y_q, dir_q[2], dir_q[3], 17'(Y_MAX));
                end
            end
            default: state_d = WAIT;
        endcase
        // Recenter overrides everything except the free-running tick counter.
        if (center) begin
            state_d = WAIT;
            last_d  = last_q;
            x_d     = 16'(X_CENTER);
            y_d     = 16'(Y_CENTER);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= WAIT;
            count_q <= '0;
            last_q  <= 1'b1;
            win_a_q <= 1'b0;
            win_b_q <= 1'b0;
            dir_q   <= '0;
            x_q     <= 16'(X_CENTER);
            y_q     <= 16'(Y_CENTER);
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            last_q  <= last_d;
            win_a_q <= win_a_d;
            win_b_q <= win_b_d;
            dir_q   <= dir_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end
endmodule
